// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg: shared types and helpers for the instruction fetch front-end.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int InstrBytes = 4;
  localparam int AlignBits  = 2;

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int instr_bytes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int align_bits(input int data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
// ----------------------------------------------------------------------------
// fetch_buf: synchronous skid FIFO with push/pop/clear; clear beats push.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_buf
  import fetch_pkg::*;
#(
  parameter int  Depth   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CntW    = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  output logic [CntW-1:0] count_o,
  output entry_t          head_o
);

  localparam int              PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count_q == CntW'(Depth));
    empty    = (count_q == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push_i & (~full | pop_i);
    do_pop   = pop_i & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_i && !pop_i && !clear_i) begin
      a_no_overflow: assert (!full);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage: RAM-driven fetch with skid buffer and redirect flush.
// Optional perf counters enabled by FETCH_PERF_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                      AddrBusWidth = 32,
  parameter int                      DataBusWidth = 32,
  parameter logic [AddrBusWidth-1:0] ResetVector  = '0,
  parameter int                      BufDepth     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [AddrBusWidth-1:0] redirect_pc,
  output logic                    mem_re,
  output logic [AddrBusWidth-1:0] mem_addr,
  input  logic [DataBusWidth-1:0] mem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AddrBusWidth-1:0] out_pc,
  output logic [DataBusWidth-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_bubble
`endif
);

  localparam int                      StepBytes = instr_bytes(DataBusWidth);
  localparam logic [AddrBusWidth-1:0] AlignMask = AddrBusWidth'(StepBytes - 1);
  localparam int                      CntW      = $clog2(BufDepth + 1);
  localparam int                      CrW       = CntW + 1;

  typedef struct packed {
    logic [AddrBusWidth-1:0] pc;
    logic [DataBusWidth-1:0] instr;
  } entry_t;

  fetch_state_e            state_q;
  logic [AddrBusWidth-1:0] pc_q;
  logic [AddrBusWidth-1:0] issued_pc_q;
  logic                    inflight_q;

  logic                    run;
  logic                    fire;
  logic                    push;
  logic [CntW-1:0]         count;
  logic [CrW-1:0]          credit;
  logic [AddrBusWidth-1:0] redirect_aligned;
  entry_t                  push_entry;
  entry_t                  head;

  assign run              = rst & (state_q == S_RUN);
  assign redirect_aligned = redirect_pc & ~AlignMask;

  // A beat presented in a redirect cycle is stale, so it is hidden from decode.
  assign out_valid = rst & (count != '0) & ~redirect_valid;
  assign fire      = out_valid & out_ready;

  // Buffered plus in-flight words, less the one leaving now, must fit the FIFO.
  assign credit   = CrW'(count) + CrW'(inflight_q) - CrW'(fire);
  assign mem_re   = run & (redirect_valid | (credit < CrW'(BufDepth)));
  assign mem_addr = redirect_valid ? redirect_aligned : pc_q;

  assign push             = inflight_q & ~redirect_valid;
  assign push_entry.pc    = issued_pc_q;
  assign push_entry.instr = mem_rdata;

  fetch_buf #(
    .Depth   (BufDepth),
    .entry_t (entry_t)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (fire),
    .count_o     (count),
    .head_o      (head)
  );

  assign out_pc    = rst ? head.pc    : '0;
  assign out_instr = rst ? head.instr : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_BOOT;
      pc_q        <= ResetVector;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else if (state_q == S_BOOT) begin
      if (redirect_valid) pc_q <= redirect_aligned;
      inflight_q <= 1'b0;
      state_q    <= S_RUN;
    end else begin
      inflight_q <= mem_re;
      if (mem_re) begin
        pc_q        <= mem_addr + AddrBusWidth'(StepBytes);
        issued_pc_q <= mem_addr;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubble_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_bubble_q  <= '0;
    end else begin
      if (fire && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (run && out_ready && !out_valid && (perf_bubble_q != '1)) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubble  = perf_bubble_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage: self-checking bench for fetch_stage against a stream model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  logic        mem_re2;
  logic [31:0] mem_addr2;
  logic [31:0] mem_rdata2;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
  logic [31:0] perf_fetched2;
  logic [31:0] perf_bubble2;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_re         (mem_re),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubble    (perf_bubble)
`endif
  );

  fetch_stage #(.ResetVector(32'hFFFF_FFFC)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .mem_re         (mem_re2),
    .mem_addr       (mem_addr2),
    .mem_rdata      (mem_rdata2),
    .out_valid      (out_valid2),
    .out_ready      (1'b1),
    .out_pc         (out_pc2),
    .out_instr      (out_instr2)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched2),
    .perf_bubble    (perf_bubble2)
`endif
  );

  // Instruction memory contents as a pure function of the byte address.
  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Synchronous-read RAMs: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_re)  mem_rdata  <= word(mem_addr);
    if (mem_re2) mem_rdata2 <= word(mem_addr2);
  end

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (mem_re !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: mem_re=%b out_valid=%b out_pc=%h out_instr=%h, required all zero",
                 mem_re, out_valid, out_pc, out_instr);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
`ifdef FETCH_PERF_EN
      if (k == 1) begin
        checks++;
        if (perf_fetched !== 32'h0 || perf_bubble !== 32'h0) begin
          errors++;
          $display("FAIL perf_after_reset: fetched=%0d bubble=%0d, required 0 0", perf_fetched, perf_bubble);
        end
      end
`endif
      checks++;
      if (out_valid !== 1'(k >= 4)) begin
        errors++;
        $display("FAIL boot_latency cycle %0d: out_valid=%b required %b", k, out_valid, 1'(k >= 4));
      end
      if (k >= 4) begin
        e = 32'((k - 4) * 4);
        checks++;
        if (out_pc !== e || out_instr !== word(e)) begin
          errors++;
          $display("FAIL boot_stream: pc=%h instr=%h required pc=%h instr=%h", out_pc, out_instr, e, word(e));
        end
      end
      @(posedge clk); #1;
    end
    exp_pc = 32'hC;
  endtask

  task automatic test_stall();
    out_ready = 1'b1; redirect_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
        errors++;
        $display("FAIL stall_pre: valid=%b pc=%h required valid=1 pc=%h", out_valid, out_pc, exp_pc);
      end
      exp_pc += 4;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        errors++;
        $display("FAIL stall_hold: valid=%b pc=%h required valid=1 pc=%h", out_valid, out_pc, exp_pc);
      end
      if (i >= 2) begin
        checks++;
        if (mem_re !== 1'b0 || mem_addr !== exp_pc + 32'd8) begin
          errors++;
          $display("FAIL stall_freeze: mem_re=%b mem_addr=%h required mem_re=0 mem_addr=%h",
                   mem_re, mem_addr, exp_pc + 32'd8);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
        errors++;
        $display("FAIL stall_resume: valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
                 out_valid, out_pc, out_instr, exp_pc, word(exp_pc));
      end
      exp_pc += 4;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    int          pre_stall [3] = '{3, 0, 0};
    logic [31:0] first_pc  [3] = '{32'h40, 32'h43, 32'h80};
    bit          twice     [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] tgt;
    for (int s = 0; s < 3; s++) begin
      out_ready = 1'b0;
      repeat (pre_stall[s]) begin @(posedge clk); #1; end
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = first_pc[s];
      tgt = first_pc[s] & ~32'h3;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || mem_re !== 1'b1 || mem_addr !== tgt) begin
        errors++;
        $display("FAIL redirect_issue s%0d: valid=%b mem_re=%b mem_addr=%h required 0 1 %h",
                 s, out_valid, mem_re, mem_addr, tgt);
      end
      @(posedge clk); #1;
      if (twice[s]) begin
        redirect_pc = 32'hC0; tgt = 32'hC0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mem_addr !== tgt) begin
          errors++;
          $display("FAIL redirect_b2b: valid=%b mem_addr=%h required 0 %h", out_valid, mem_addr, tgt);
        end
        @(posedge clk); #1;
      end
      redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL redirect_gap s%0d: valid=%b required 0", s, out_valid);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== tgt || out_instr !== word(tgt)) begin
          errors++;
          $display("FAIL redirect_stream s%0d: valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
                   s, out_valid, out_pc, out_instr, tgt, word(tgt));
        end
        tgt += 4;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    out_ready = 1'b0; redirect_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || mem_re !== 1'b0 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b mem_re=%b pc=%h required 0 0 0", out_valid, mem_re, out_pc);
    end
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
`ifdef FETCH_PERF_EN
      if (k == 1) begin
        checks++;
        if (perf_fetched !== 32'h0 || perf_bubble !== 32'h0) begin
          errors++;
          $display("FAIL perf_mid_reset: fetched=%0d bubble=%0d, required 0 0", perf_fetched, perf_bubble);
        end
      end
`endif
      checks++;
      if (out_valid !== 1'(k >= 4)) begin
        errors++;
        $display("FAIL restart_latency cycle %0d: out_valid=%b required %b", k, out_valid, 1'(k >= 4));
      end
      if (k >= 4) begin
        e = 32'((k - 4) * 4);
        checks++;
        if (out_pc !== e || out_instr !== word(e)) begin
          errors++;
          $display("FAIL restart_stream: pc=%h instr=%h required pc=%h instr=%h", out_pc, out_instr, e, word(e));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit got;
    for (int c = 0; c < 400; c++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = (c == 0) || ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      @(negedge clk);
      if (redirect_valid) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL random_redirect_valid: out_valid=%b required 0", out_valid);
        end
        exp_pc = redirect_pc & ~32'h3;
      end else if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
          errors++;
          $display("FAIL random_fire: pc=%h instr=%h required pc=%h instr=%h",
                   out_pc, out_instr, exp_pc, word(exp_pc));
        end
        exp_pc += 4;
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0; out_ready = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL random_drain_timeout: out_valid=%b required 1 within 6 cycles", out_valid);
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
          errors++;
          $display("FAIL random_steady: valid=%b pc=%h required valid=1 pc=%h", out_valid, out_pc, exp_pc);
        end
        exp_pc += 4;
        @(posedge clk); #1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    bit got;
    got = 1'b0;
    rst = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid2 === 1'b1) begin
        got = 1'b1;
        checks++;
        if (k != 4 || out_pc2 !== 32'hFFFF_FFFC || out_instr2 !== word(32'hFFFF_FFFC)) begin
          errors++;
          $display("FAIL wrap_first: cycle=%0d pc=%h instr=%h required cycle=4 pc=fffffffc instr=%h",
                   k, out_pc2, out_instr2, word(32'hFFFF_FFFC));
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid2 !== 1'b1 || out_pc2 !== 32'h0 || out_instr2 !== 32'h0000_0013) begin
          errors++;
          $display("FAIL wrap_second: valid=%b pc=%h instr=%h required 1 00000000 00000013",
                   out_valid2, out_pc2, out_instr2);
        end
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: out_valid2 never rose within 8 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
